// File: rtl/rotor_step_sequencer.sv
// Rotor stepping FSM: one key -> right/middle/left rotor advance, step_done 2 cycles after acceptance, one key per 3 cycles.
// Optional macro ROTOR_DOUBLE_STEP_EN enables the historical middle-rotor double-step.
module rotor_step_sequencer #(
    parameter logic [4:0] NOTCH_R = 5'd16,
    parameter logic [4:0] NOTCH_M = 5'd4,
    parameter logic [4:0] NOTCH_L = 5'd21
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_req,
    input  logic [4:0]  init_l,
    input  logic [4:0]  init_m,
    input  logic [4:0]  init_r,
    input  logic        key_valid,
    output logic        key_ready,
    output logic [4:0]  pos_l,
    output logic [4:0]  pos_m,
    output logic [4:0]  pos_r,
    output logic        step_done,
    output logic [15:0] key_count
);

    if (NOTCH_R > 5'd25 || NOTCH_M > 5'd25 || NOTCH_L > 5'd25) begin : g_bad_notch
        $error("rotor_step_sequencer: notch positions must be 0-25");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic       key_accept;
    logic       mid_adv;
    logic       left_adv;
    logic [4:0] step_l, step_m, step_r;

    function automatic logic [4:0] wrap_inc(input logic [4:0] p);
        return (p >= 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    function automatic logic [4:0] clamp_init(input logic [4:0] p);
        return (p > 5'd25) ? 5'd0 : p;
    endfunction

    // reset gates key_ready so no key is taken while the block is held in reset
    assign key_ready  = (state == IDLE) && !load_req && !reset;
    assign key_accept = key_valid && key_ready;
    assign step_done  = (state == DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (key_accept) state_nxt = STEP;
            STEP:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (load_req) state_nxt = IDLE;
    end

    // all notch tests look at the pre-step positions
    always_comb begin
        left_adv = (pos_m == NOTCH_M);
`ifdef ROTOR_DOUBLE_STEP_EN
        mid_adv  = (pos_r == NOTCH_R) || (pos_m == NOTCH_M);
`else
        mid_adv  = (pos_r == NOTCH_R);
`endif
        step_r = wrap_inc(pos_r);
        step_m = mid_adv  ? wrap_inc(pos_m) : pos_m;
        step_l = left_adv ? wrap_inc(pos_l) : pos_l;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pos_l     <= 5'd0;
            pos_m     <= 5'd0;
            pos_r     <= 5'd0;
            key_count <= 16'd0;
        end else begin
            state <= state_nxt;
            if (load_req) begin
                pos_l     <= clamp_init(init_l);
                pos_m     <= clamp_init(init_m);
                pos_r     <= clamp_init(init_r);
                key_count <= 16'd0;
            end else begin
                if (state == STEP) begin
                    pos_l <= step_l;
                    pos_m <= step_m;
                    pos_r <= step_r;
                end
                if (key_accept) key_count <= key_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rotor_step_sequencer.sv
// Randomized bench for rotor_step_sequencer against a positional rotor model.
module tb_rotor_step_sequencer;

    localparam int NR = 16;
    localparam int NM = 4;
`ifdef ROTOR_DOUBLE_STEP_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_req = 1'b0;
    logic [4:0]  init_l = '0, init_m = '0, init_r = '0;
    logic        key_valid = 1'b0;
    logic        key_ready;
    logic [4:0]  pos_l, pos_m, pos_r;
    logic        step_done;
    logic [15:0] key_count;

    int checks = 0;
    int failures = 0;
    int ml = 0, mm = 0, mr = 0, mcnt = 0;

    always #5 clk = ~clk;

    rotor_step_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .load_req  (load_req),
        .init_l    (init_l),
        .init_m    (init_m),
        .init_r    (init_r),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .pos_l     (pos_l),
        .pos_m     (pos_m),
        .pos_r     (pos_r),
        .step_done (step_done),
        .key_count (key_count)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_l"}, pos_l, ml);
        check({tag, "_m"}, pos_m, mm);
        check({tag, "_r"}, pos_r, mr);
    endtask

    function automatic void model_step();
        bit mid, left;
        mid  = (mr == NR) || (DBL && mm == NM);
        left = (mm == NM);
        mr = (mr + 1) % 26;
        if (mid)  mm = (mm + 1) % 26;
        if (left) ml = (ml + 1) % 26;
    endfunction

    // Drive key_valid until accepted, then check the two-cycle step timeline.
    task automatic press_key();
        int waited = 0;
        @(negedge clk);
        key_valid = 1'b1;
        while (!key_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        if (!key_ready) begin
            check("accept_timeout", 0, 1);
            key_valid = 1'b0;
            return;
        end
        @(posedge clk);
        mcnt = (mcnt + 1) % 65536;
        @(negedge clk);
        key_valid = 1'b0;
        check("count_at_step", key_count, mcnt);
        check("done_early", step_done, 0);
        check_pos("pos_hold_step");
        model_step();
        @(negedge clk);
        check("done_pulse", step_done, 1);
        check_pos("pos_after_step");
        @(negedge clk);
        check("done_clear", step_done, 0);
        check("ready_idle", key_ready, 1);
        check_pos("pos_hold_idle");
    endtask

    task automatic do_load(input int l, input int m, input int r, input bit with_key, input int hold);
        @(negedge clk);
        load_req  = 1'b1;
        key_valid = with_key;
        init_l = 5'(l); init_m = 5'(m); init_r = 5'(r);
        for (int i = 0; i < hold; i++) begin
            #1 check("ready_during_load", key_ready, 0);
            @(negedge clk);
        end
        load_req  = 1'b0;
        key_valid = 1'b0;
        ml = (l <= 25) ? l : 0;
        mm = (m <= 25) ? m : 0;
        mr = (r <= 25) ? r : 0;
        mcnt = 0;
        check_pos("pos_load");
        check("count_load", key_count, 0);
        check("done_load", step_done, 0);
    endtask

    initial begin
        #12;
        check("rst_pos_l", pos_l, 0);
        check("rst_pos_r", pos_r, 0);
        check("rst_count", key_count, 0);
        check("rst_done", step_done, 0);
        check("rst_ready", key_ready, 0);
        @(negedge clk);
        reset = 1'b0;

        // first key after reset, then basic and boundary loads
        press_key();
        check("first_key_r", pos_r, 1);
        do_load(0, 0, 0, 1'b0, 1);
        press_key();
        check("basic_r", pos_r, 1);
        check("basic_count", key_count, 1);
        do_load(0, 0, 16, 1'b0, 1);
        press_key();
        check("rnotch_m", pos_m, 1);
        check("rnotch_r", pos_r, 17);
        do_load(0, 3, 16, 1'b0, 1);
        press_key();
        check("ds1_l", pos_l, 0);
        check("ds1_m", pos_m, 4);
        check("ds1_r", pos_r, 17);
        press_key();
        check("ds2_l", pos_l, 1);
        check("ds2_m", pos_m, DBL ? 5 : 4);
        check("ds2_r", pos_r, 18);
        do_load(25, 25, 25, 1'b0, 1);
        press_key();
        check("wrap_r", pos_r, 0);
        do_load(3, 30, 7, 1'b0, 1);
        check("clamp_m", pos_m, 0);
        do_load(9, 10, 11, 1'b1, 3);
        check("loadkey_r", pos_r, 11);

        // load while a step is in flight: abandon without step_done
        @(negedge clk);
        key_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0;
        load_req = 1'b1;
        init_l = 5'd20; init_m = 5'd21; init_r = 5'd22;
        @(negedge clk);
        load_req = 1'b0;
        ml = 20; mm = 21; mr = 22; mcnt = 0;
        check_pos("abandon_load");
        check("abandon_count", key_count, 0);
        for (int i = 0; i < 3; i++) begin
            check("abandon_nodone", step_done, 0);
            @(negedge clk);
        end

        // reset during STEP
        @(negedge clk);
        key_valid = 1'b1;
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        key_valid = 1'b0;
        check("mid_rst_pos_l", pos_l, 0);
        check("mid_rst_pos_m", pos_m, 0);
        check("mid_rst_pos_r", pos_r, 0);
        check("mid_rst_count", key_count, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_rst_ready", key_ready, 0);
            check("mid_rst_nodone", step_done, 0);
        end
        reset = 1'b0;
        ml = 0; mm = 0; mr = 0; mcnt = 0;
        press_key();

        // randomized mix of loads and keypresses
        for (int it = 0; it < 80; it++) begin
            int idle = $urandom_range(0, 2);
            for (int k = 0; k < idle; k++) @(negedge clk);
            if ($urandom_range(0, 4) == 0)
                do_load($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                        1'($urandom_range(0, 1)), $urandom_range(1, 2));
            else if ($urandom_range(0, 3) == 0)
                // bias toward notch positions to exercise carries
                do_load($urandom_range(0, 25), NM - 1 + $urandom_range(0, 1),
                        NR - 1 + $urandom_range(0, 1), 1'b0, 1);
            else
                press_key();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rotor_step_sequencer.md
ROTOR_STEP_SEQUENCER -- requirements
Module: rotor_step_sequencer

Interface
REQ-001 The block SHALL have parameter NOTCH_R, default 5'd16, right-rotor turnover position.
REQ-002 The block SHALL have parameter NOTCH_M, default 5'd4, middle-rotor turnover position.
REQ-003 The block SHALL have parameter NOTCH_L, default 5'd21, left-rotor notch position (informational; left never carries further).
REQ-004 The block SHALL have port clk  input  1  rising-edge system clock.
REQ-005 The block SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have port load_req  input  1  load initial rotor positions.
REQ-007 The block SHALL have port init_l, init_m, init_r  input  5 each  requested start positions.
REQ-008 The block SHALL have port key_valid  input  1  keypress request, held until accepted.
REQ-009 The block SHALL have port key_ready  output  1  keypress accepted when key_valid and key_ready are both high at a clk edge.
REQ-010 The block SHALL have port pos_l, pos_m, pos_r  output  5 each  current rotor positions, 0-25.
REQ-011 The block SHALL have port step_done  output  1  one-cycle pulse after positions update.
REQ-012 The block SHALL have port key_count  output  16  number of accepted keypresses since reset or load.

Function
REQ-013 The FSM SHALL have states IDLE, STEP, DONE, all registered on clk.
REQ-014 key_ready SHALL equal (state==IDLE) and not load_req.
REQ-015 In IDLE, an accepted keypress SHALL move the FSM to STEP at that edge.
REQ-016 In STEP, the next edge SHALL update positions per REQ-017..REQ-020 and move the FSM to DONE.
REQ-017 pos_r SHALL advance by one on every step.
REQ-018 pos_m SHALL advance by one when pre-step pos_r equals NOTCH_R, or when double-stepping applies (REQ-030).
REQ-019 pos_l SHALL advance by one when pre-step pos_m equals NOTCH_M.
REQ-020 Every position increment SHALL wrap from 25 to 0; all notch tests SHALL use pre-step values.
REQ-021 In DONE, step_done SHALL be 1 for exactly that cycle, and the FSM SHALL return to IDLE at the next edge.
REQ-022 Keypress-to-step_done latency SHALL be 2 cycles after the accepting edge; maximum throughput SHALL be one key per 3 cycles.
REQ-023 key_count SHALL increment at the accepting edge and wrap from 65535 to 0.
REQ-024 load_req SHALL be honoured in any state: at the next edge each pos_x SHALL be loaded with init_x if init_x <= 25, else 0; key_count SHALL clear; the FSM SHALL go to IDLE; any in-flight step SHALL be abandoned without a step_done pulse.
REQ-025 With load_req and key_valid both high in IDLE, the load SHALL win and the key SHALL NOT be accepted.
REQ-026 Positions SHALL NOT change in IDLE or DONE except by load or reset.

Reset
REQ-027 reset SHALL asynchronously force the FSM to IDLE; pos_l, pos_m, pos_r, key_count to 0; and step_done to 0.
REQ-028 While reset is high, key_ready SHALL be 0; reset asserted mid-STEP SHALL abandon the step without a step_done pulse.
REQ-029 After reset deasserts, the block SHALL accept a key on the first clk edge at which key_valid is high.

Configuration
REQ-030 With macro ROTOR_DOUBLE_STEP_EN defined, pos_m SHALL also advance when pre-step pos_m equals NOTCH_M (historical double-step anomaly).
REQ-031 Without ROTOR_DOUBLE_STEP_EN, pos_m SHALL advance only on the REQ-018 right-notch condition, giving odometer stepping.

Verification
REQ-032 Reset, then load 0/0/0 and press one key: pos_r=1, step_done high 2 cycles after acceptance, key_count=1.
REQ-033 Load l=0, m=0, r=16 and press a key: r=17, m=1, l=0.
REQ-034 With ROTOR_DOUBLE_STEP_EN, load 0/3/16 and press 2 keys: 0/4/17 after the first key, then 1/5/18; without the macro: 0/4/17, then 1/4/18.
REQ-035 Load 25/25/25 and step: r wraps to 0; load init_m=30: pos_m=0.
REQ-036 Hold key_valid and load_req high in IDLE: key not accepted; positions equal the init values; key_count=0.
REQ-037 Assert reset during STEP: outputs zero immediately, no step_done pulse, key_ready=0 while reset is high.
